// File: rtl/digit_seq_checker.sv
// -----------------------------------------------------------------------------
// digit_seq_checker
//
// Combination-lock style checker. The user commits BCD digits one at a time
// with an enter pulse. After N_DIGITS digits the block reports either MATCH or
// FAIL. The full code is always collected before the verdict, so a wrong
// digit gives no early hint. After MAX_FAILS consecutive failed attempts the
// block locks out all input for LOCK_CYCLES clock cycles.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high; overrides every other input
//   digit_in[3:0] in  digit to commit (10..15 never match)
//   enter        in   one-cycle pulse, commits digit_in
//   clear        in   one-cycle pulse, aborts entry / acknowledges result;
//                     wins over enter in the same cycle
//   match        out  registered, high while in MATCH
//   fail         out  registered, high while in FAIL
//   locked       out  registered, high while in LOCKOUT
//   digit_count[3:0] out registered, digits committed in the current attempt
//   fails[1:0]   out  registered, consecutive failed attempts
// -----------------------------------------------------------------------------
module digit_seq_checker #(
   parameter int unsigned           N_DIGITS    = 4,
   parameter logic [4*N_DIGITS-1:0] CODE        = 16'h1954,
   parameter int unsigned           MAX_FAILS   = 3,
   parameter int unsigned           LOCK_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit_in,
   input  logic       enter,
   input  logic       clear,
   output logic       match,
   output logic       fail,
   output logic       locked,
   output logic [3:0] digit_count,
   output logic [1:0] fails
);

   // Timer must hold LOCK_CYCLES-1; keep at least one bit for LOCK_CYCLES=1.
   localparam int unsigned     TW         = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [TW-1:0]   LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
   localparam logic [1:0]      FAIL_LIMIT = 2'(MAX_FAILS);
   localparam logic [3:0]      LAST_IDX   = 4'(N_DIGITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_MATCH,
      S_FAIL,
      S_LOCKOUT
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          mm_q, mm_d;       // sticky "some digit was wrong" flag
   logic [1:0]    fails_q, fails_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          match_q, fail_q, locked_q;

   logic [3:0]    code_digit;
   logic          digit_bad;
   logic [1:0]    fails_inc;

   // Expected digit for the position about to be committed. cnt_q is 0 in
   // IDLE, so the same lookup serves the first digit.
   always_comb begin
      code_digit = '0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (cnt_q == 4'(i)) code_digit = CODE[4*(int'(N_DIGITS)-1-i) +: 4];
      end
   end

   assign digit_bad = (digit_in != code_digit);
   assign fails_inc = fails_q + 2'd1;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mm_d    = mm_q;
      fails_d = fails_q;
      timer_d = timer_q;

      unique case (state_q)
         S_IDLE: begin
            // clear in IDLE is a no-op: count and flag are already zero.
            if (!clear && enter) begin
               state_d = S_ENTRY;
               cnt_d   = 4'd1;
               mm_d    = digit_bad;
            end
         end

         S_ENTRY: begin
            if (clear) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               mm_d    = 1'b0;
            end else if (enter) begin
               if (cnt_q == LAST_IDX) begin
                  cnt_d = '0;
                  mm_d  = 1'b0;
                  if (mm_q || digit_bad) begin
                     fails_d = fails_inc;
                     if (fails_inc == FAIL_LIMIT) begin
                        state_d = S_LOCKOUT;
                        timer_d = LOCK_LOAD;
                     end else begin
                        state_d = S_FAIL;
                     end
                  end else begin
                     state_d = S_MATCH;
                     fails_d = '0;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
                  mm_d  = mm_q | digit_bad;
               end
            end
         end

         S_MATCH, S_FAIL: begin
            // Result is held until acknowledged; enter is ignored.
            if (clear) state_d = S_IDLE;
         end

         S_LOCKOUT: begin
            // Exit on the cycle the timer reads 0, so LOCKOUT lasts exactly
            // LOCK_LOAD+1 = LOCK_CYCLES cycles and the timer never wraps.
            if (timer_q == '0) begin
               state_d = S_IDLE;
               fails_d = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            mm_d    = 1'b0;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values and ordering inside the block is irrelevant.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mm_q     <= 1'b0;
         fails_q  <= '0;
         timer_q  <= '0;
         match_q  <= 1'b0;
         fail_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mm_q     <= mm_d;
         fails_q  <= fails_d;
         timer_q  <= timer_d;
         // Status flags are decoded from the next state so they appear in the
         // cycle right after the deciding edge, straight from a flop.
         match_q  <= (state_d == S_MATCH);
         fail_q   <= (state_d == S_FAIL);
         locked_q <= (state_d == S_LOCKOUT);
      end
   end

   assign match       = match_q;
   assign fail        = fail_q;
   assign locked      = locked_q;
   assign digit_count = cnt_q;
   assign fails       = fails_q;

endmodule

// File: tb/tb_digit_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_digit_seq_checker
//
// Bench for digit_seq_checker with CODE=16'h1954, N_DIGITS=4, MAX_FAILS=3,
// LOCK_CYCLES=8. Each scenario task builds a plan of one-cycle steps; the
// expected output word for each step is pushed to a scoreboard queue as the
// stimulus is driven and popped for comparison once the DUT has clocked it.
// Output word layout: {match, fail, locked, digit_count[3:0], fails[1:0]}.
// -----------------------------------------------------------------------------
module tb_digit_seq_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] digit_in = '0;
   logic       enter = 1'b0;
   logic       clear = 1'b0;
   logic       match, fail, locked;
   logic [3:0] digit_count;
   logic [1:0] fails;

   digit_seq_checker #(
      .N_DIGITS    (4),
      .CODE        (16'h1954),
      .MAX_FAILS   (3),
      .LOCK_CYCLES (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .digit_in    (digit_in),
      .enter       (enter),
      .clear       (clear),
      .match       (match),
      .fail        (fail),
      .locked      (locked),
      .digit_count (digit_count),
      .fails       (fails)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       en;
      logic       cl;
      logic [3:0] d;
      logic [8:0] exp;
   } step_t;

   step_t      plan[$];
   logic [8:0] sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   function automatic logic [8:0] obs();
      return {match, fail, locked, digit_count, fails};
   endfunction

   // Append one cycle: inputs (rst, en, cl, d) and the outputs expected
   // after that edge (m, f, l, c, fs).
   task automatic add(input logic rst, input logic en, input logic cl,
                      input int d, input logic m, input logic f, input logic l,
                      input int c, input int fs);
      step_t s;
      s.rst = rst; s.en = en; s.cl = cl; s.d = 4'(d);
      s.exp = {m, f, l, 4'(c), 2'(fs)};
      plan.push_back(s);
   endtask

   // Drive one cycle of inputs, clock it, and return to idle inputs at #1
   // after the edge (outputs are sampled there too).
   task automatic apply(input step_t s);
      reset = s.rst; enter = s.en; clear = s.cl; digit_in = s.d;
      @(posedge clk);
      #1;
      reset = 1'b0; enter = 1'b0; clear = 1'b0;
   endtask

   task automatic test_reset();
      logic [8:0] e;
      plan.delete();
      add(1, 0, 0, 0,  0, 0, 0, 0, 0);
      add(1, 1, 0, 1,  0, 0, 0, 0, 0);   // reset beats enter
      add(0, 0, 0, 0,  0, 0, 0, 0, 0);
      foreach (plan[i]) begin
         sb.push_back(plan[i].exp);
         apply(plan[i]);
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset step %0d: got %b expected %b", i, obs(), e);
         end
      end
   endtask

   task automatic test_match();
      logic [8:0] e;
      plan.delete();
      add(1, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);
      add(0, 1, 0, 9,  0, 0, 0, 2, 0);
      add(0, 1, 0, 5,  0, 0, 0, 3, 0);
      add(0, 1, 0, 4,  1, 0, 0, 0, 0);   // verdict right after the 4th enter
      add(0, 0, 0, 0,  1, 0, 0, 0, 0);   // held
      add(0, 1, 0, 7,  1, 0, 0, 0, 0);   // enter ignored in MATCH
      add(0, 0, 1, 0,  0, 0, 0, 0, 0);   // clear -> IDLE
      foreach (plan[i]) begin
         sb.push_back(plan[i].exp);
         apply(plan[i]);
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL match step %0d: got %b expected %b", i, obs(), e);
         end
      end
   endtask

   task automatic test_fail();
      logic [8:0] e;
      plan.delete();
      add(1, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);
      add(0, 1, 0, 9,  0, 0, 0, 2, 0);
      add(0, 1, 0, 5,  0, 0, 0, 3, 0);
      add(0, 1, 0, 3,  0, 1, 0, 0, 1);   // last digit wrong
      add(0, 1, 0, 7,  0, 1, 0, 0, 1);   // enter ignored in FAIL
      add(0, 0, 0, 0,  0, 1, 0, 0, 1);
      add(0, 0, 1, 0,  0, 0, 0, 0, 1);   // clear keeps fails
      foreach (plan[i]) begin
         sb.push_back(plan[i].exp);
         apply(plan[i]);
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL fail step %0d: got %b expected %b", i, obs(), e);
         end
      end
   endtask

   task automatic test_abort();
      logic [8:0] e;
      plan.delete();
      add(1, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);
      add(0, 1, 0, 9,  0, 0, 0, 2, 0);
      add(0, 0, 1, 0,  0, 0, 0, 0, 0);   // abort, not a failure
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);
      add(0, 1, 0, 9,  0, 0, 0, 2, 0);
      add(0, 1, 0, 5,  0, 0, 0, 3, 0);
      add(0, 1, 0, 4,  1, 0, 0, 0, 0);
      add(0, 0, 1, 0,  0, 0, 0, 0, 0);
      foreach (plan[i]) begin
         sb.push_back(plan[i].exp);
         apply(plan[i]);
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL abort step %0d: got %b expected %b", i, obs(), e);
         end
      end
   endtask

   task automatic test_lockout();
      logic [8:0] e;
      plan.delete();
      add(1, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 1, 0, 0,  0, 0, 0, 1, 0);   // wrong from the first digit,
      add(0, 1, 0, 0,  0, 0, 0, 2, 0);   // but no early abort
      add(0, 1, 0, 0,  0, 0, 0, 3, 0);
      add(0, 1, 0, 0,  0, 1, 0, 0, 1);
      add(0, 0, 1, 0,  0, 0, 0, 0, 1);
      add(0, 1, 0, 1,  0, 0, 0, 1, 1);
      add(0, 1, 0, 9,  0, 0, 0, 2, 1);
      add(0, 1, 0, 5,  0, 0, 0, 3, 1);
      add(0, 1, 0, 15, 0, 1, 0, 0, 2);   // non-BCD digit mismatches
      add(0, 0, 1, 0,  0, 0, 0, 0, 2);
      add(0, 1, 0, 0,  0, 0, 0, 1, 2);
      add(0, 1, 0, 0,  0, 0, 0, 2, 2);
      add(0, 1, 0, 0,  0, 0, 0, 3, 2);
      add(0, 1, 0, 0,  0, 0, 1, 0, 3);   // lockout cycle 1, fail stays low
      add(0, 1, 0, 1,  0, 0, 1, 0, 3);   // cycles 2..8, input ignored
      add(0, 0, 1, 0,  0, 0, 1, 0, 3);
      add(0, 1, 1, 1,  0, 0, 1, 0, 3);
      add(0, 0, 0, 0,  0, 0, 1, 0, 3);
      add(0, 1, 0, 1,  0, 0, 1, 0, 3);
      add(0, 0, 0, 0,  0, 0, 1, 0, 3);
      add(0, 0, 1, 0,  0, 0, 1, 0, 3);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0);   // back to IDLE, fails cleared
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);   // accepts entry again
      foreach (plan[i]) begin
         sb.push_back(plan[i].exp);
         apply(plan[i]);
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL lockout step %0d: got %b expected %b", i, obs(), e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] e;
      plan.delete();
      add(1, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);
      add(0, 1, 1, 9,  0, 0, 0, 0, 0);   // clear wins, digit dropped
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);   // IDLE takes the next enter
      add(0, 1, 0, 9,  0, 0, 0, 2, 0);
      add(0, 1, 0, 5,  0, 0, 0, 3, 0);
      add(1, 1, 0, 4,  0, 0, 0, 0, 0);   // reset mid-entry beats final enter
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);   // enter accepted right after reset
      add(0, 1, 0, 9,  0, 0, 0, 2, 0);
      add(0, 1, 0, 5,  0, 0, 0, 3, 0);
      add(0, 1, 0, 4,  1, 0, 0, 0, 0);
      foreach (plan[i]) begin
         sb.push_back(plan[i].exp);
         apply(plan[i]);
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got %b expected %b", i, obs(), e);
         end
      end
   endtask

   task automatic test_fail_recovery();
      logic [8:0] e;
      plan.delete();
      add(1, 0, 0, 0,  0, 0, 0, 0, 0);
      add(0, 1, 0, 2,  0, 0, 0, 1, 0);
      add(0, 1, 0, 9,  0, 0, 0, 2, 0);
      add(0, 1, 0, 5,  0, 0, 0, 3, 0);
      add(0, 1, 0, 4,  0, 1, 0, 0, 1);   // wrong first digit only
      add(0, 0, 1, 0,  0, 0, 0, 0, 1);
      add(0, 1, 0, 1,  0, 0, 0, 1, 1);
      add(0, 1, 0, 8,  0, 0, 0, 2, 1);
      add(0, 1, 0, 5,  0, 0, 0, 3, 1);
      add(0, 1, 0, 4,  0, 1, 0, 0, 2);
      add(0, 0, 1, 0,  0, 0, 0, 0, 2);
      add(0, 1, 0, 1,  0, 0, 0, 1, 2);
      add(0, 1, 0, 9,  0, 0, 0, 2, 2);
      add(0, 1, 0, 5,  0, 0, 0, 3, 2);
      add(0, 1, 0, 4,  1, 0, 0, 0, 0);   // success clears fail history
      add(0, 0, 1, 0,  0, 0, 0, 0, 0);
      add(0, 1, 0, 1,  0, 0, 0, 1, 0);
      add(0, 1, 0, 9,  0, 0, 0, 2, 0);
      add(0, 1, 0, 6,  0, 0, 0, 3, 0);
      add(0, 1, 0, 4,  0, 1, 0, 0, 1);   // single fail, no lockout
      add(0, 0, 0, 0,  0, 1, 0, 0, 1);
      foreach (plan[i]) begin
         sb.push_back(plan[i].exp);
         apply(plan[i]);
         e = sb.pop_front();
         n_tests++;
         if (obs() !== e) begin
            n_fail++;
            $display("FAIL fail_recovery step %0d: got %b expected %b", i, obs(), e);
         end
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_match();
      test_fail();
      test_abort();
      test_lockout();
      test_back_to_back();
      test_fail_recovery();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_seq_checker.md
DIGIT_SEQ_CHECKER -- requirements
Module: digit_seq_checker

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, giving the number of digits per code (legal range 2..8).
REQ-002 The block SHALL have parameter CODE, default 16'h1954, width 4*N_DIGITS. The first-entered digit is compared against CODE[4*N_DIGITS-1 -: 4], the last against CODE[3:0].
REQ-003 The block SHALL have parameter MAX_FAILS, default 3, giving the number of consecutive failed attempts that triggers lockout (legal range 1..3).
REQ-004 The block SHALL have parameter LOCK_CYCLES, default 50_000_000, giving the lockout duration in clk cycles (1 s at 50 MHz).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 digit_in  input  4  BCD digit from SW[3:0]; values 10..15 are legal inputs and always mismatch.
REQ-008 enter  input  1  one-cycle pulse, already synchronized and edge-detected upstream; commits digit_in.
REQ-009 clear  input  1  one-cycle pulse; aborts the current entry or acknowledges a result.
REQ-010 match  output  1  registered; high while in MATCH.
REQ-011 fail  output  1  registered; high while in FAIL.
REQ-012 locked  output  1  registered; high while in LOCKOUT.
REQ-013 digit_count  output  4  registered; number of digits committed in the current attempt.
REQ-014 fails  output  2  registered; count of consecutive failed attempts.

Function
REQ-015 The block SHALL implement the states IDLE, ENTRY, MATCH, FAIL and LOCKOUT.
REQ-016 IDLE: digit_count=0 and the mismatch flag is clear. Enter SHALL transition to ENTRY with digit_count=1 and mismatch set to (digit_in != expected digit 0).
REQ-017 ENTRY: each enter SHALL increment digit_count and OR (digit_in != expected digit[digit_count]) into the mismatch flag. There is no early abort on the first wrong digit.
REQ-018 On the enter that commits digit N_DIGITS, the next state SHALL be MATCH if the combined mismatch (stored flag OR current compare) is 0, else FAIL.
REQ-019 Latency: match/fail SHALL be high in the cycle immediately after the clock edge that samples the final enter.
REQ-020 MATCH: match SHALL be held and fails SHALL be set to 0; enter is ignored; clear returns the block to IDLE.
REQ-021 On entering FAIL, fails SHALL increment. If the new value equals MAX_FAILS, the state SHALL go to LOCKOUT instead of FAIL: fail stays low, locked goes high, and the timer loads LOCK_CYCLES-1.
REQ-022 FAIL: fail SHALL be held; enter is ignored; clear returns the block to IDLE with fails retained.
REQ-023 LOCKOUT: the timer SHALL decrement every cycle, and enter and clear are ignored. When the timer reads 0, the next state SHALL be IDLE with fails=0, so locked is high for exactly LOCK_CYCLES cycles.
REQ-024 Clear in IDLE or ENTRY SHALL return the block to IDLE with digit_count=0 and the mismatch flag cleared. This is not counted as a failure.
REQ-025 If clear and enter are asserted in the same cycle, clear SHALL win and the digit is discarded.
REQ-026 digit_count SHALL read 0 in IDLE, MATCH, FAIL and LOCKOUT. It never exceeds N_DIGITS and never wraps.
REQ-027 The lockout timer SHALL be sized ceil(log2(LOCK_CYCLES)) bits and SHALL not underflow.

Reset
REQ-028 Reset SHALL take priority over all inputs.
REQ-029 On reset the state SHALL be IDLE, and match, fail, locked, digit_count, fails, the mismatch flag and the timer SHALL all be 0.
REQ-030 A reset asserted mid-entry or mid-lockout SHALL abandon the operation, and the block SHALL accept enter in the first cycle after reset deasserts.

Verification (CODE=16'h1954, N_DIGITS=4, MAX_FAILS=3, LOCK_CYCLES=8)
REQ-031 Enter 1,9,5,4 -> digit_count 1,2,3,4→0; match=1 one cycle after the 4th enter; fails=0; clear -> IDLE, match=0.
REQ-032 Enter 1,9,5,3 -> fail=1, fails=1, and match never high; enter 7 while in FAIL -> no change; clear -> IDLE.
REQ-033 Enter 1,9, then clear, then 1,9,5,4 -> match=1, fails=0, and the abort is not counted.
REQ-034 Three wrong codes (e.g. 0,0,0,0 and 1,9,5,15 with clears between) -> fails=1,2, then locked=1 for exactly 8 cycles with fail=0; enter/clear ignored during lockout; then IDLE with fails=0.
REQ-035 Enter and clear asserted together on the 2nd digit -> digit_count=0 and state IDLE. Separately, reset asserted in ENTRY with digit_count=3 -> all outputs 0 on the next cycle.
REQ-036 Two fails, then the correct code -> match=1, fails=0; a subsequent single fail -> fails=1, no lockout.
